// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the segmented pipelined adder.
// Provides the operation encoding, per-stage sideband and pipeline-depth helper.
package pipe_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Sideband travelling with each transfer; the MSBs feed the final overflow test.
  typedef struct packed {
    logic valid;
    op_e  op;
    logic sat;
    logic a_msb;
    logic b_msb;
  } side_t;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
    return (width + seg - 1) / seg;
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The producer/consumer side uses master; the adder uses slave.
interface pipe_adder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, sat, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, sat, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );

endinterface

// File: rtl/adder_seg.sv
// One registered slice of the carry chain: sums a segment and registers the
// segment result and its carry-out when enabled.
module adder_seg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] a_seg,
  input  logic [W-1:0] b_seg,
  input  logic         cin,
  output logic [W-1:0] s_seg,
  output logic         cout
);

  logic [W-1:0] s_d, s_q;
  logic         cout_d, cout_q;

  always_comb begin
    {cout_d, s_d} = {1'b0, a_seg} + {1'b0, b_seg} + {{W{1'b0}}, cin};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else if (en) begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign s_seg = s_q;
  assign cout  = cout_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract with one carry-chain segment per stage,
// valid/ready backpressure, unsigned saturation and carry/overflow flags.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEG   = 4
) (
  input logic        clk,
  input logic        reset,
  pipe_adder_if.slave bus
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG);

  side_t            side_d [NSEG];
  side_t            side_q [NSEG];
  logic [WIDTH-1:0] a_d    [NSEG];
  logic [WIDTH-1:0] a_q    [NSEG];
  logic [WIDTH-1:0] b_d    [NSEG];
  logic [WIDTH-1:0] b_q    [NSEG];
  logic [WIDTH-1:0] r_d    [NSEG];
  logic [WIDTH-1:0] r_q    [NSEG];
  logic [WIDTH-1:0] seg_ext[NSEG];
  logic [NSEG-1:0]  cout_w;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin0;
  side_t            in_side;
  side_t            out_side;
  logic [WIDTH-1:0] raw;
  logic             c_raw;

  assign advance      = !side_q[NSEG-1].valid || bus.out_ready;
  assign bus.in_ready = advance || reset;

  // Subtraction is a + ~b + 1, so the forced carry-in replaces c_in.
  always_comb begin
    b_eff         = bus.sub ? ~bus.b : bus.b;
    cin0          = bus.sub | bus.c_in;
    in_side.valid = bus.in_valid;
    in_side.op    = bus.sub ? OP_SUB : OP_ADD;
    in_side.sat   = bus.sat;
    in_side.a_msb = bus.a[WIDTH-1];
    in_side.b_msb = b_eff[WIDTH-1];
  end

  always_comb begin
    side_d[0] = in_side;
    a_d[0]    = bus.a;
    b_d[0]    = b_eff;
    r_d[0]    = '0;
    for (int k = 1; k < NSEG; k++) begin
      side_d[k] = side_q[k-1];
      a_d[k]    = a_q[k-1];
      b_d[k]    = b_q[k-1];
      r_d[k]    = r_q[k-1] | seg_ext[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSEG; k++) begin
        side_q[k] <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        r_q[k]    <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < NSEG; k++) begin
        side_q[k] <= side_d[k];
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        r_q[k]    <= r_d[k];
      end
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int unsigned LO = k * SEG;
    localparam int unsigned HI = ((k + 1) * SEG > WIDTH) ? WIDTH - 1 : (k + 1) * SEG - 1;
    localparam int unsigned W  = HI - LO + 1;

    logic [W-1:0] a_seg;
    logic [W-1:0] b_seg;
    logic [W-1:0] s_seg;
    logic         cin;

    if (k == 0) begin : g_first
      assign a_seg = bus.a[HI:LO];
      assign b_seg = b_eff[HI:LO];
      assign cin   = cin0;
    end else begin : g_rest
      // Operands come from the previous stage so they stay aligned with its carry.
      assign a_seg = a_q[k-1][HI:LO];
      assign b_seg = b_q[k-1][HI:LO];
      assign cin   = cout_w[k-1];
    end

    adder_seg #(
      .W(W)
    ) u_seg (
      .clk   (clk),
      .reset (reset),
      .en    (advance),
      .a_seg (a_seg),
      .b_seg (b_seg),
      .cin   (cin),
      .s_seg (s_seg),
      .cout  (cout_w[k])
    );

    assign seg_ext[k] = WIDTH'(s_seg) << LO;
  end

  assign out_side = side_q[NSEG-1];
  assign raw      = r_q[NSEG-1] | seg_ext[NSEG-1];
  assign c_raw    = cout_w[NSEG-1];

  always_comb begin
    bus.sum = raw;
    if (out_side.sat) begin
      if (out_side.op == OP_ADD && c_raw) begin
        bus.sum = '1;
      end else if (out_side.op == OP_SUB && !c_raw) begin
        bus.sum = '0;
      end
    end
    bus.c_out     = c_raw;
    bus.ovf       = (out_side.a_msb == out_side.b_msb) && (raw[WIDTH-1] != out_side.a_msb);
    bus.out_valid = out_side.valid;
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and randomized checks of pipe_adder in three configurations:
// 8/4 (two stages), 13/5 (three stages) and 8/8 (single stage).
module tb_pipe_adder;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  pipe_adder_if #(.WIDTH(8))  if_a ();
  pipe_adder_if #(.WIDTH(13)) if_b ();
  pipe_adder_if #(.WIDTH(8))  if_c ();

  pipe_adder #(.WIDTH(8), .SEG(4)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
  pipe_adder #(.WIDTH(13), .SEG(5)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b));
  pipe_adder #(.WIDTH(8), .SEG(8)) u_dut_c (.clk(clk), .reset(reset), .bus(if_c));

  logic [31:0] q_b[$];
  logic [31:0] q_c[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Whole-width reference result packed as {ovf, c_out, sum}.
  function automatic logic [31:0] ref_res(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub, input logic sat);
    logic [31:0] mask, bp, t, raw, s;
    logic        c, ovf;
    mask = (32'd1 << w) - 32'd1;
    bp   = (sub ? ~b : b) & mask;
    t    = (a & mask) + bp + {31'd0, (sub ? 1'b1 : cin)};
    raw  = t & mask;
    c    = t[w];
    ovf  = (a[w-1] == bp[w-1]) && (raw[w-1] != a[w-1]);
    s    = raw;
    if (sat && !sub && c) s = mask;
    if (sat && sub && !c) s = 32'd0;
    return ({31'd0, ovf} << (w + 1)) | ({31'd0, c} << w) | s;
  endfunction

  // Single transfer through the 8/4 instance; result expected exactly two cycles later.
  task automatic one_a(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input logic sat,
                       input logic [7:0] e_sum, input logic e_c, input logic e_ovf);
    @(negedge clk);
    if_a.in_valid  = 1'b1;
    if_a.a         = a;
    if_a.b         = b;
    if_a.c_in      = cin;
    if_a.sub       = sub;
    if_a.sat       = sat;
    if_a.out_ready = 1'b1;
    #1 check({tag, "_rdy"}, {31'd0, if_a.in_ready}, 32'd1);
    @(negedge clk);
    if_a.in_valid = 1'b0;
    #1 check({tag, "_lat1"}, {31'd0, if_a.out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_vld"}, {31'd0, if_a.out_valid}, 32'd1);
    check({tag, "_sum"}, {24'd0, if_a.sum}, {24'd0, e_sum});
    check({tag, "_cout"}, {31'd0, if_a.c_out}, {31'd0, e_c});
    check({tag, "_ovf"}, {31'd0, if_a.ovf}, {31'd0, e_ovf});
  endtask

  task automatic step_b();
    if (if_b.out_valid && if_b.out_ready) begin
      if (q_b.size() == 0) check("rnd13_spurious", {31'd0, if_b.out_valid}, 32'd0);
      else check("rnd13", {17'd0, if_b.ovf, if_b.c_out, if_b.sum}, q_b.pop_front());
    end
    if (if_b.in_valid && if_b.in_ready)
      q_b.push_back(ref_res(13, {19'd0, if_b.a}, {19'd0, if_b.b}, if_b.c_in, if_b.sub, if_b.sat));
  endtask

  task automatic step_c();
    if (if_c.out_valid && if_c.out_ready) begin
      if (q_c.size() == 0) check("rnd8_spurious", {31'd0, if_c.out_valid}, 32'd0);
      else check("rnd8", {22'd0, if_c.ovf, if_c.c_out, if_c.sum}, q_c.pop_front());
    end
    if (if_c.in_valid && if_c.in_ready)
      q_c.push_back(ref_res(8, {24'd0, if_c.a}, {24'd0, if_c.b}, if_c.c_in, if_c.sub, if_c.sat));
  endtask

  initial begin
    int idx;
    int nout;
    int lat;

    reset          = 1'b1;
    if_a.in_valid  = 1'b1;
    if_a.a         = 8'hAA;
    if_a.b         = 8'h55;
    if_a.c_in      = 1'b1;
    if_a.sub       = 1'b0;
    if_a.sat       = 1'b0;
    if_a.out_ready = 1'b1;
    if_b.in_valid  = 1'b0;
    if_b.a         = '0;
    if_b.b         = '0;
    if_b.c_in      = 1'b0;
    if_b.sub       = 1'b0;
    if_b.sat       = 1'b0;
    if_b.out_ready = 1'b1;
    if_c.in_valid  = 1'b0;
    if_c.a         = '0;
    if_c.b         = '0;
    if_c.c_in      = 1'b0;
    if_c.sub       = 1'b0;
    if_c.sat       = 1'b0;
    if_c.out_ready = 1'b1;

    // Reset held for three cycles with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_vld", {31'd0, if_a.out_valid}, 32'd0);
      check("rst_sum", {24'd0, if_a.sum}, 32'd0);
      check("rst_cout", {31'd0, if_a.c_out}, 32'd0);
      check("rst_ovf", {31'd0, if_a.ovf}, 32'd0);
      check("rst_rdy", {31'd0, if_a.in_ready}, 32'd1);
    end
    check("rst_vld13", {31'd0, if_b.out_valid}, 32'd0);
    check("rst_vld1", {31'd0, if_c.out_valid}, 32'd0);
    reset         = 1'b0;
    if_a.in_valid = 1'b0;

    one_a("add2", 8'h02, 8'h02, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0);
    one_a("addc", 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0);
    one_a("adds", 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    one_a("addv", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    one_a("subb", 8'h05, 8'h07, 1'b1, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    one_a("subs", 8'h05, 8'h07, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    one_a("subv", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

    // Back-to-back stream with the consumer stalled for cycles 3..5.
    idx  = 0;
    nout = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if_a.in_valid  = (idx < 6);
      if_a.a         = 8'(idx);
      if_a.b         = 8'h10;
      if_a.c_in      = 1'b0;
      if_a.sub       = 1'b0;
      if_a.sat       = 1'b0;
      if_a.out_ready = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) begin
        check("stall_rdy", {31'd0, if_a.in_ready}, 32'd0);
        check("stall_sum", {24'd0, if_a.sum}, 32'h11);
      end
      if (if_a.out_valid && if_a.out_ready) begin
        check($sformatf("stream%0d", nout), {24'd0, if_a.sum}, 32'h10 + 32'(nout));
        nout++;
      end
      if (if_a.in_valid && if_a.in_ready) idx++;
    end
    check("stream_count", 32'(nout), 32'd6);
    check("stream_accepted", 32'(idx), 32'd6);

    // Reset with two transfers in flight.
    @(negedge clk);
    if_a.in_valid  = 1'b1;
    if_a.a         = 8'h01;
    if_a.b         = 8'h01;
    if_a.out_ready = 1'b1;
    @(negedge clk);
    if_a.a = 8'h02;
    if_a.b = 8'h02;
    @(negedge clk);
    if_a.in_valid = 1'b0;
    reset         = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 check("flush_vld", {31'd0, if_a.out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("flush_stale", {31'd0, if_a.out_valid}, 32'd0);
    end
    one_a("fresh", 8'h03, 8'h04, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    // Latency of the three-stage configuration; carry ripples through every segment.
    @(negedge clk);
    if_b.in_valid = 1'b1;
    if_b.a        = 13'h0ABC;
    if_b.b        = 13'h1543;
    if_b.c_in     = 1'b1;
    @(negedge clk);
    if_b.in_valid = 1'b0;
    lat           = 1;
    #1;
    while (!if_b.out_valid && lat < 10) begin
      @(negedge clk);
      #1 lat++;
    end
    check("lat13", 32'(lat), 32'd3);
    check("lat13_sum", {19'd0, if_b.sum}, 32'd0);
    check("lat13_cout", {31'd0, if_b.c_out}, 32'd1);

    // Latency of the single-stage configuration, saturating signed-overflow add.
    @(negedge clk);
    if_c.in_valid = 1'b1;
    if_c.a        = 8'h80;
    if_c.b        = 8'h80;
    if_c.sat      = 1'b1;
    @(negedge clk);
    if_c.in_valid = 1'b0;
    lat           = 1;
    #1;
    while (!if_c.out_valid && lat < 10) begin
      @(negedge clk);
      #1 lat++;
    end
    check("lat1", 32'(lat), 32'd1);
    check("lat1_sum", {24'd0, if_c.sum}, 32'hFF);
    check("lat1_cout", {31'd0, if_c.c_out}, 32'd1);
    check("lat1_ovf", {31'd0, if_c.ovf}, 32'd1);
    @(negedge clk);

    // Random traffic with random backpressure on both extra configurations.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if_b.in_valid  = ($urandom_range(0, 3) != 0);
      if_b.out_ready = ($urandom_range(0, 2) != 0);
      if_b.a         = 13'($urandom_range(0, 8191));
      if_b.b         = 13'($urandom_range(0, 8191));
      if_b.c_in      = 1'($urandom_range(0, 1));
      if_b.sub       = 1'($urandom_range(0, 1));
      if_b.sat       = 1'($urandom_range(0, 1));
      if_c.in_valid  = ($urandom_range(0, 3) != 0);
      if_c.out_ready = ($urandom_range(0, 2) != 0);
      if_c.a         = 8'($urandom_range(0, 255));
      if_c.b         = 8'($urandom_range(0, 255));
      if_c.c_in      = 1'($urandom_range(0, 1));
      if_c.sub       = 1'($urandom_range(0, 1));
      if_c.sat       = 1'($urandom_range(0, 1));
      #1;
      step_b();
      step_c();
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if_b.in_valid  = 1'b0;
      if_b.out_ready = 1'b1;
      if_c.in_valid  = 1'b0;
      if_c.out_ready = 1'b1;
      #1;
      step_b();
      step_c();
    end
    check("rnd13_drained", 32'(q_b.size()), 32'd0);
    check("rnd8_drained", 32'(q_c.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
